counter: RTL and testbench



---
 rtl/counter_pkg.sv | 13 +
 rtl/counter_modn.sv | 28 ++
 rtl/counter.sv | 59 +++++
 tb/tb_counter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared constants and helpers for the counter clock divider.
package counter_pkg;

  localparam int DEFAULT_DIV_COUNT = 25_000_000;

  // Counter width for a mod-n count. The result is never below 1, so DIV_COUNT=1 still gets one bit.
  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/counter_modn.sv
// Mod-N up-counter with async active-low reset and a combinational terminal-count flag.
module counter_modn
  import counter_pkg::*;
#(
  parameter int N = 4,
  parameter int W = cnt_width(N)
) (
  input  logic         clk,
  input  logic         res,
  output logic [W-1:0] cnt,
  output logic         term
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  assign term = (cnt == LAST);

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      cnt <= '0;
    end else if (term) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/counter.sv
// Free-running clock divider: opt toggles every DIV_COUNT rising edges (period 2*DIV_COUNT).
// Build macro COUNTER_TC_OUT_EN adds a registered one-cycle tc pulse aligned with each opt change.
module counter
  import counter_pkg::*;
#(
  parameter int DIV_COUNT = DEFAULT_DIV_COUNT
) (
  input  logic clk,
  input  logic res,
`ifdef COUNTER_TC_OUT_EN
  output logic opt,
  output logic tc
`else
  output logic opt
`endif
);

  localparam int CNT_W = cnt_width(DIV_COUNT);

  if (DIV_COUNT < 1) begin : g_bad_div
    $error("counter: DIV_COUNT must be at least 1");
  end

  logic [CNT_W-1:0] cnt;
  logic             term;

  counter_modn #(
    .N (DIV_COUNT),
    .W (CNT_W)
  ) u_modn (
    .clk  (clk),
    .res  (res),
    .cnt  (cnt),
    .term (term)
  );

  // opt comes straight from this flop, so there is no combinational path from res or clk.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      opt <= 1'b0;
    end else if (term) begin
      opt <= ~opt;
    end
  end

`ifdef COUNTER_TC_OUT_EN
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      tc <= 1'b0;
    end else begin
      tc <= term;
    end
  end
`endif

  // Every terminal count is followed by a wrap to zero.
  a_wrap_to_zero: assert property (@(posedge clk) disable iff (!res) term |=> (cnt == '0));

endmodule

// File: tb/tb_counter.sv
// Directed bench for counter: several divide ratios, reset behaviour, and the optional tc pulse.
`timescale 1ns/1ps
module tb_counter;

  logic clk;
  logic res;
  logic opt4, opt1, opt5, opt3, optl;
`ifdef COUNTER_TC_OUT_EN
  logic tc4, tc1, tc5, tc3, tcl;
`endif

  int tests_run;
  int tests_failed;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef COUNTER_TC_OUT_EN
  counter #(.DIV_COUNT(4))    u4 (.clk(clk), .res(res), .opt(opt4), .tc(tc4));
  counter #(.DIV_COUNT(1))    u1 (.clk(clk), .res(res), .opt(opt1), .tc(tc1));
  counter #(.DIV_COUNT(5))    u5 (.clk(clk), .res(res), .opt(opt5), .tc(tc5));
  counter #(.DIV_COUNT(3))    u3 (.clk(clk), .res(res), .opt(opt3), .tc(tc3));
  counter #(.DIV_COUNT(1000)) ul (.clk(clk), .res(res), .opt(optl), .tc(tcl));
`else
  counter #(.DIV_COUNT(4))    u4 (.clk(clk), .res(res), .opt(opt4));
  counter #(.DIV_COUNT(1))    u1 (.clk(clk), .res(res), .opt(opt1));
  counter #(.DIV_COUNT(5))    u5 (.clk(clk), .res(res), .opt(opt5));
  counter #(.DIV_COUNT(3))    u3 (.clk(clk), .res(res), .opt(opt3));
  counter #(.DIV_COUNT(1000)) ul (.clk(clk), .res(res), .opt(optl));
`endif

  // ---------------- driver tasks ----------------
  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold reset for n edges, then release on a falling edge so the next rising edge is edge 1.
  task automatic do_reset(input int n);
    res = 1'b0;
    repeat (n) tick();
    @(negedge clk);
    res = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    res = 1'b0;
    #2;
    for (int k = 0; k < 10; k++) begin
      tick();
      tests_run++;
      if ({opt4, opt1, opt5, opt3, optl} !== 5'b0) begin
        tests_failed++;
        $display("FAIL reset_hold cycle %0d: opt bits=%b expected 00000", k, {opt4, opt1, opt5, opt3, optl});
      end
    end
    @(negedge clk);
    res = 1'b1;
    repeat (5) tick();
    tests_run++;
    if (opt4 !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_pre_async: opt4=%b expected 1", opt4);
    end
    #2;
    res = 1'b0;
    #1;
    tests_run++;
    if (opt4 !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_async_clear: opt4=%b expected 0", opt4);
    end
  endtask

  task automatic test_basic_divide();
    logic exp;
    do_reset(2);
    for (int k = 1; k <= 16; k++) begin
      tick();
      exp = ((k / 4) % 2) == 1;
      tests_run++;
      if (opt4 !== exp) begin
        tests_failed++;
        $display("FAIL basic_div4 edge %0d: opt=%b expected %b", k, opt4, exp);
      end
    end
  endtask

  task automatic test_min_divide();
    logic exp;
    do_reset(2);
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp = (k % 2) == 1;
      tests_run++;
      if (opt1 !== exp) begin
        tests_failed++;
        $display("FAIL min_div1 edge %0d: opt=%b expected %b", k, opt1, exp);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic exp;
    do_reset(2);
    repeat (7) tick();
    tests_run++;
    if (opt5 !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_reset_before edge 7: opt=%b expected 1", opt5);
    end
    #2;
    res = 1'b0;
    #1;
    tests_run++;
    if (opt5 !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_reset_clear: opt=%b expected 0", opt5);
    end
    repeat (2) tick();
    @(negedge clk);
    res = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      exp = ((k / 5) % 2) == 1;
      tests_run++;
      if (opt5 !== exp) begin
        tests_failed++;
        $display("FAIL mid_reset_restart edge %0d: opt=%b expected %b", k, opt5, exp);
      end
    end
  endtask

  task automatic test_long_run();
    int toggles;
    int bad_edge;
    logic prev;
    toggles  = 0;
    bad_edge = -1;
    do_reset(2);
    prev = optl;
    for (int k = 1; k <= 4000; k++) begin
      tick();
      if (optl !== prev) begin
        toggles++;
        if ((k % 1000) != 0 && bad_edge < 0) bad_edge = k;
      end
      prev = optl;
    end
    tests_run++;
    if (toggles != 4) begin
      tests_failed++;
      $display("FAIL long_toggle_count: got %0d expected 4", toggles);
    end
    tests_run++;
    if (bad_edge >= 0) begin
      tests_failed++;
      $display("FAIL long_toggle_edge: toggle at edge %0d expected multiples of 1000", bad_edge);
    end
    tests_run++;
    if (optl !== 1'b0) begin
      tests_failed++;
      $display("FAIL long_final_opt: opt=%b expected 0", optl);
    end
  endtask

  task automatic test_div3();
    logic exp_opt;
`ifdef COUNTER_TC_OUT_EN
    logic exp_tc;
    res = 1'b0;
    #1;
    tests_run++;
    if (tc3 !== 1'b0) begin
      tests_failed++;
      $display("FAIL tc_in_reset: tc=%b expected 0", tc3);
    end
`endif
    do_reset(2);
    for (int k = 1; k <= 12; k++) begin
      tick();
      exp_opt = ((k / 3) % 2) == 1;
      tests_run++;
      if (opt3 !== exp_opt) begin
        tests_failed++;
        $display("FAIL div3_opt edge %0d: opt=%b expected %b", k, opt3, exp_opt);
      end
`ifdef COUNTER_TC_OUT_EN
      exp_tc = (k % 3) == 0;
      tests_run++;
      if (tc3 !== exp_tc) begin
        tests_failed++;
        $display("FAIL div3_tc edge %0d: tc=%b expected %b", k, tc3, exp_tc);
      end
`endif
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    tests_run    = 0;
    tests_failed = 0;
    res          = 1'b0;
    test_reset();
    test_basic_divide();
    test_min_divide();
    test_mid_reset();
    test_long_run();
    test_div3();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
